aes_inv_key_sched: RTL and testbench

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_inv_key_sched.sv | 157 +++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: walks an AES-128 key schedule backwards, starting from
// round key LAST_ROUND and emitting every round key down to round 0 over a
// valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      begin one inverse expansion (sampled only in IDLE)
//   last_key   round key LAST_ROUND, word w0 in bits [127:96]
//   key_ready  consumer accepts key_out this cycle
//   key_out    current round key, same word order as last_key
//   key_valid  key_out / round_idx are valid
//   round_idx  round number of key_out, LAST_ROUND down to 0
//   busy       expansion in progress
//   done       one-cycle pulse after round key 0 is accepted

// Byte S-box: multiplicative inverse in GF(2^8) followed by the AES affine map.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] AFF_C = 8'h63;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] acc;
      logic [7:0] m;
      acc = '0;
      m   = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) acc = acc ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] inv;

   always_comb begin
      // a^254 == a^-1 for nonzero a and maps 0 to 0; exponent bits 1111_1110
      inv = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (i != 0) inv = gf_mul(inv, a);
      end
      y = '0;
      for (int i = 0; i < 8; i++)
         y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ AFF_C[i];
   end
endmodule

module aes_inv_key_sched #(
   parameter int LAST_ROUND = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] last_key,
   input  logic         key_ready,
   output logic [127:0] key_out,
   output logic         key_valid,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);
   typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FIN = 2'd2} state_t;

   state_t       state, state_nxt;
   logic [127:0] key_q, key_nxt;
   logic [3:0]   cnt_q, cnt_nxt;
   logic         hs;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Inverse step: previous key words from current key words
   logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
   logic [127:0] key_prev;

   assign w0  = key_q[127:96];
   assign w1  = key_q[95:64];
   assign w2  = key_q[63:32];
   assign w3  = key_q[31:0];
   assign p3  = w3 ^ w2;
   assign p2  = w2 ^ w1;
   assign p1  = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_sbox
         aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
      end
   endgenerate

   assign p0       = w0 ^ sub ^ {rcon(cnt_q), 24'h0};
   assign key_prev = {p0, p1, p2, p3};

   assign hs = (state == EMIT) && key_ready;

   always_comb begin
      state_nxt = state;
      key_nxt   = key_q;
      cnt_nxt   = cnt_q;
      case (state)
         IDLE: begin
            if (start) begin
               key_nxt   = last_key;
               cnt_nxt   = 4'(LAST_ROUND);
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (hs) begin
               if (cnt_q == 4'd0) begin
                  state_nxt = FIN;
               end else begin
                  key_nxt = key_prev;
                  cnt_nxt = cnt_q - 4'd1;
               end
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         key_q <= '0;
         cnt_q <= '0;
      end else begin
         state <= state_nxt;
         key_q <= key_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   assign key_out   = key_q;
   assign round_idx = cnt_q;
   assign key_valid = (state == EMIT);
   assign busy      = (state == EMIT);
   assign done      = (state == FIN);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;
   logic         clk = 1'b0;
   logic         rst_n, start, key_ready;
   logic [127:0] last_key, key_out;
   logic         key_valid, busy, done;
   logic [3:0]   round_idx;

   logic         start1, key_ready1;
   logic [127:0] last_key1, key_out1;
   logic         key_valid1, busy1, done1;
   logic [3:0]   round_idx1;

   always #5 clk = ~clk;

   aes_inv_key_sched #(.LAST_ROUND(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
      .key_ready(key_ready), .key_out(key_out), .key_valid(key_valid),
      .round_idx(round_idx), .busy(busy), .done(done));

   aes_inv_key_sched #(.LAST_ROUND(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .last_key(last_key1),
      .key_ready(key_ready1), .key_out(key_out1), .key_valid(key_valid1),
      .round_idx(round_idx1), .busy(busy1), .done(done1));

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;

   logic [7:0]   sb [256];
   logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [127:0] obs [11];

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Polynomial product reduced modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] prev_key(input logic [127:0] k, input int r);
      logic [31:0] w [4];
      logic [31:0] p [4];
      logic [31:0] t;
      for (int j = 0; j < 4; j++) w[j] = k[127 - 32*j -: 32];
      p[3] = w[3] ^ w[2];
      p[2] = w[2] ^ w[1];
      p[1] = w[1] ^ w[0];
      t = {p[3][23:0], p[3][31:24]};
      t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      p[0] = w[0] ^ t ^ {rcon_tab[r-1], 24'h0};
      return {p[0], p[1], p[2], p[3]};
   endfunction

   // One expansion on the LAST_ROUND=10 instance.
   //   rnd_ready : key_ready follows a random pattern
   //   mid_start : pulse start with another key while at round 6
   //   abort_at  : apply a one-cycle reset when this round is showing (-1 = never)
   //   hold_start: keep start high throughout, then check back-to-back restart
   task automatic run10(input logic [127:0] k, input bit rnd_ready, input bit mid_start,
                        input int abort_at, input bit hold_start);
      logic [127:0] ex [11];
      int idx, cyc;
      ex[10] = k;
      for (int r = 10; r >= 1; r--) ex[r-1] = prev_key(ex[r], r);
      @(negedge clk);
      chk("idle_valid", key_valid, 1'b0);
      start = 1'b1; last_key = k; key_ready = 1'b0;
      @(negedge clk);
      if (!hold_start) begin start = 1'b0; last_key = ~k; end
      idx = 10; cyc = 0;
      while (idx >= 0 && cyc < 400) begin
         chk("key_valid", key_valid, 1'b1);
         chk("busy", busy, 1'b1);
         chk("round_idx", round_idx, 128'(idx));
         chk("key_out", key_out, ex[idx]);
         obs[idx] = key_out;
         if (abort_at == idx) begin
            rst_n = 1'b0; key_ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("rst_valid", key_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_key", key_out, 128'h0);
            chk("rst_idx", round_idx, 4'h0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("abort_no_done", {done, key_valid}, 2'b00);
            end
            return;
         end
         if (mid_start && idx == 6) begin start = 1'b1; last_key = ~k ^ 128'h5a; end
         else if (!hold_start) start = 1'b0;
         key_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (key_ready) idx--;
         @(negedge clk);
         cyc++;
      end
      chk("all_keys_accepted", idx < 0, 1'b1);
      chk("fin_done", done, 1'b1);
      chk("fin_valid", key_valid, 1'b0);
      chk("fin_busy", busy, 1'b0);
      @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_valid2", key_valid, 1'b0);
      if (hold_start) begin
         @(negedge clk);
         chk("restart_valid", key_valid, 1'b1);
         chk("restart_idx", round_idx, 4'd10);
         chk("restart_key", key_out, k);
      end
   endtask

   initial begin
      logic [127:0] rk;
      init_sbox();
      rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; last_key = '0;
      start1 = 1'b0; key_ready1 = 1'b1; last_key1 = '0;
      repeat (2) @(negedge clk);
      chk("reset_key", key_out, 128'h0);
      chk("reset_idx", round_idx, 4'h0);
      chk("reset_flags", {key_valid, busy, done}, 3'b000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_flags", {key_valid, busy, done}, 3'b000);
      chk("idle_key", key_out, 128'h0);

      // FIPS-197 vector, ready always high
      run10(K10, 1'b0, 1'b0, -1, 1'b0);
      chk("fips_k9", obs[9], K9);
      chk("fips_k0", obs[0], K0);
      // same vector under random backpressure
      run10(K10, 1'b1, 1'b0, -1, 1'b0);
      chk("bp_k0", obs[0], K0);
      // start pulsed mid-expansion is ignored
      run10(K10, 1'b0, 1'b1, -1, 1'b0);
      chk("midstart_k0", obs[0], K0);
      // random keys, random backpressure
      for (int n = 0; n < 3; n++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         run10(rk, 1'b1, 1'b0, -1, 1'b0);
      end
      // reset while round 5 is showing, then a fresh full run
      run10(K10, 1'b0, 1'b0, 5, 1'b0);
      run10(K10, 1'b0, 1'b0, -1, 1'b0);
      chk("after_abort_k0", obs[0], K0);
      // start and ready held high: one IDLE cycle between done and next key
      rk = {$urandom, $urandom, $urandom, $urandom};
      run10(rk, 1'b0, 1'b0, -1, 1'b1);
      start = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // LAST_ROUND=1 instance
      @(negedge clk);
      chk("lr1_idle", key_valid1, 1'b0);
      start1 = 1'b1; last_key1 = K1;
      @(negedge clk);
      start1 = 1'b0;
      chk("lr1_valid", key_valid1, 1'b1);
      chk("lr1_idx1", round_idx1, 4'd1);
      chk("lr1_key1", key_out1, K1);
      @(negedge clk);
      chk("lr1_idx0", round_idx1, 4'd0);
      chk("lr1_key0", key_out1, K0);
      @(negedge clk);
      chk("lr1_done", {done1, key_valid1, busy1}, 3'b100);
      @(negedge clk);
      chk("lr1_idle2", {done1, key_valid1, busy1}, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
